// File: rtl/tl_pkg.sv
// Transaction Layer shared types: completion status codes, Fmt/Type codes and the
// decoded-completion record handed to the read-return path.
package tl_pkg;

    typedef enum logic [2:0] {
        SC  = 3'd0,
        UR  = 3'd1,
        CRS = 3'd2,
        CA  = 3'd4
    } tl_cpl_status_e;

    localparam logic [7:0] FMTTYPE_CPL  = 8'h0A;
    localparam logic [7:0] FMTTYPE_CPLD = 8'h4A;

    typedef struct packed {
        logic [7:0]      tag;
        tl_cpl_status_e  status;
        logic [15:0]     cmpl_id;
        logic [10:0]     len_dw;
        logic [12:0]     byte_cnt;
        logic [6:0]      lower_addr;
        logic            has_data;
        logic            last;
    } tl_cpl_info_t;

endpackage

// File: rtl/tl_cpl_last_calc.sv
// Decides whether a completion is the final one of its request: a CplD is last when its
// remaining byte count fits in the payload it carries; a data-less Cpl always ends the request.
module tl_cpl_last_calc (
    input  logic [10:0] len_dw_i,
    input  logic [12:0] byte_cnt_i,
    input  logic [6:0]  lower_addr_i,
    input  logic        has_data_i,
    output logic        last_o
);

    logic [13:0] bc_ext;
    logic [13:0] payload_bytes;
    logic        unused_la;

    // Only the DW offset of lower_addr trims the first payload DW.
    assign unused_la = ^lower_addr_i[6:2];

    always_comb begin
        bc_ext        = {1'b0, byte_cnt_i};
        payload_bytes = ({3'b000, len_dw_i} << 2) - {12'b0, lower_addr_i[1:0]};
        last_o        = has_data_i ? (bc_ext <= payload_bytes) : 1'b1;
    end

endmodule

// File: rtl/tl_cpl_hdr_dec.sv
// RX Completion header decoder: classifies inbound headers, checks them against outstanding
// tags and presents decoded completions. Optional counters under TL_CPL_HDR_DEC_STATS_EN.
module tl_cpl_hdr_dec
    import tl_pkg::*;
#(
    parameter int unsigned TAG_W        = 8,
    parameter logic [15:0] REQUESTER_ID = 16'h0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [127:0]          hdr_i,
    input  logic                  hdr_valid_i,
    output logic                  hdr_ready_o,
    input  logic [2**TAG_W-1:0]   tag_busy_i,
    output logic                  cpl_valid_o,
    input  logic                  cpl_ready_i,
    output tl_cpl_info_t          cpl_info_o,
    output logic                  tag_release_o,
    output logic [TAG_W-1:0]      tag_release_id_o,
`ifdef TL_CPL_HDR_DEC_STATS_EN
    output logic [31:0]           stat_cpl_cnt_o,
    output logic [31:0]           stat_err_cnt_o,
`endif
    output logic                  err_unsupported_o,
    output logic                  err_unexp_cpl_o,
    output logic                  err_malformed_o
);

    typedef enum logic [1:0] {StIdle, StDecode, StEmit, StDrop} state_e;

    // err_q bit order: {unsupported, unexpected, malformed}
    state_e       state_q, state_d;
    logic [127:0] hdr_q, hdr_d;
    tl_cpl_info_t info_q, info_d;
    logic [2:0]   err_q, err_d;

    logic [7:0]       fmt_type;
    logic             is_cpl, is_cpld;
    logic [10:0]      dec_len;
    logic [12:0]      dec_byte_cnt;
    tl_cpl_status_e   dec_status;
    logic [7:0]       dec_tag;
    logic [TAG_W-1:0] dec_tag_lo;
    logic             tag_hi_nz;
    logic             dec_unsup, dec_unexp, dec_malf;
    logic             dec_last;
    tl_cpl_info_t     dec_info;
    logic             cpl_hs;
    logic             unused_hdr;

    assign unused_hdr = ^{hdr_q[119:106], hdr_q[76], hdr_q[39], hdr_q[31:0]};

    always_comb begin
        fmt_type     = hdr_q[127:120];
        is_cpl       = (fmt_type == FMTTYPE_CPL);
        is_cpld      = (fmt_type == FMTTYPE_CPLD);
        dec_len      = (hdr_q[105:96] == 10'd0) ? 11'd1024 : {1'b0, hdr_q[105:96]};
        dec_byte_cnt = (hdr_q[75:64] == 12'd0) ? 13'd4096 : {1'b0, hdr_q[75:64]};
        dec_status   = tl_cpl_status_e'(hdr_q[79:77]);
        dec_tag      = hdr_q[47:40];
        dec_tag_lo   = dec_tag[TAG_W-1:0];
        // Tags wider than the Tag Table can never be outstanding.
        tag_hi_nz    = (({24'b0, dec_tag}) >> TAG_W) != 32'd0;
        dec_unsup    = !(is_cpl || is_cpld);
        dec_unexp    = (hdr_q[63:48] != REQUESTER_ID) || tag_hi_nz || !tag_busy_i[dec_tag_lo];
        dec_malf     = (is_cpl && (dec_status == SC)) || (is_cpld && (dec_status != SC));

        dec_info            = '0;
        dec_info.tag        = dec_tag;
        dec_info.status     = dec_status;
        dec_info.cmpl_id    = hdr_q[95:80];
        dec_info.len_dw     = dec_len;
        dec_info.byte_cnt   = dec_byte_cnt;
        dec_info.lower_addr = hdr_q[38:32];
        dec_info.has_data   = is_cpld;
        dec_info.last       = dec_last;
    end

    tl_cpl_last_calc u_last_calc (
        .len_dw_i     (dec_len),
        .byte_cnt_i   (dec_byte_cnt),
        .lower_addr_i (hdr_q[38:32]),
        .has_data_i   (is_cpld),
        .last_o       (dec_last)
    );

    always_comb begin
        state_d = state_q;
        hdr_d   = hdr_q;
        info_d  = info_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle: begin
                if (hdr_valid_i) begin
                    hdr_d   = hdr_i;
                    state_d = StDecode;
                end
            end
            StDecode: begin
                if (dec_unsup) begin
                    err_d   = 3'b100;
                    state_d = StDrop;
                end else if (dec_unexp) begin
                    err_d   = 3'b010;
                    state_d = StDrop;
                end else if (dec_malf) begin
                    err_d   = 3'b001;
                    state_d = StDrop;
                end else begin
                    err_d   = 3'b000;
                    info_d  = dec_info;
                    state_d = StEmit;
                end
            end
            StEmit: begin
                if (cpl_ready_i) begin
                    state_d = StIdle;
                end
            end
            StDrop: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            hdr_q   <= '0;
            info_q  <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            hdr_q   <= hdr_d;
            info_q  <= info_d;
            err_q   <= err_d;
        end
    end

    // Ready is masked by reset so the async-reset IDLE state does not advertise acceptance.
    always_comb begin
        hdr_ready_o       = rst_n && (state_q == StIdle);
        cpl_valid_o       = (state_q == StEmit);
        cpl_info_o        = info_q;
        cpl_hs            = cpl_valid_o && cpl_ready_i;
        tag_release_o     = cpl_hs && info_q.last;
        tag_release_id_o  = tag_release_o ? info_q.tag[TAG_W-1:0] : '0;
        err_unsupported_o = (state_q == StDrop) && err_q[2];
        err_unexp_cpl_o   = (state_q == StDrop) && err_q[1];
        err_malformed_o   = (state_q == StDrop) && err_q[0];
    end

`ifdef TL_CPL_HDR_DEC_STATS_EN
    logic [31:0] stat_cpl_cnt_q, stat_cpl_cnt_d;
    logic [31:0] stat_err_cnt_q, stat_err_cnt_d;

    always_comb begin
        stat_cpl_cnt_d = stat_cpl_cnt_q;
        stat_err_cnt_d = stat_err_cnt_q;
        if (cpl_hs && (stat_cpl_cnt_q != 32'hFFFF_FFFF)) begin
            stat_cpl_cnt_d = stat_cpl_cnt_q + 32'd1;
        end
        if ((state_q == StDrop) && (stat_err_cnt_q != 32'hFFFF_FFFF)) begin
            stat_err_cnt_d = stat_err_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_cpl_cnt_q <= '0;
            stat_err_cnt_q <= '0;
        end else begin
            stat_cpl_cnt_q <= stat_cpl_cnt_d;
            stat_err_cnt_q <= stat_err_cnt_d;
        end
    end

    assign stat_cpl_cnt_o = stat_cpl_cnt_q;
    assign stat_err_cnt_o = stat_err_cnt_q;
`endif

endmodule
